regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised integer register file for the core's decode/write-back boundary. It provides NREAD combinational read ports and one write port, with load-width formatting on the write data. Same-cycle write-to-read bypass removes the one-cycle write-back hazard. A per-register busy scoreboard lets decode stall on registers that still have an outstanding producer.

## Interface
Parameters:
- XLEN, 32, register width in bits (≥16)
- NREGS, 32, number of architectural registers (power of 2; register 0 hardwired to zero)
- NREAD, 2, number of read ports
- AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_address  in  NREAD*AW  packed read addresses; port i uses bits [i*AW +: AW]
- data_out  out  NREAD*XLEN  packed read data; port i uses bits [i*XLEN +: XLEN]
- rd_busy  out  NREAD  port i's register has an outstanding producer
- wr_enable  in  1  write strobe
- wr_address  in  AW  write destination
- wr_data  in  XLEN  raw write-back data
- write_pattern  in  3  formatting mode, using the REG_WRITE_* encodings from parameters.vh
- issue_valid  in  1  decode issues an instruction with a destination register
- issue_address  in  AW  destination of the issued instruction
- busy_count  out  AW+1  number of registers currently marked busy

## Operation
- Storage is NREGS×XLEN flops. Register 0 always reads 0, is never written and is never marked busy.
- write_pattern encodings, with the formatted value fmt:
  - REG_WRITE_WORD=3'b000: fmt = wr_data
  - REG_WRITE_BYTE_UNSIGNED=3'b001: fmt = zero-extended wr_data[7:0]
  - REG_WRITE_BYTE_SIGNED=3'b010: fmt = sign-extended wr_data[7:0]
  - REG_WRITE_HALF_UNSIGNED=3'b011: fmt = zero-extended wr_data[15:0]
  - REG_WRITE_HALF_SIGNED=3'b100: fmt = sign-extended wr_data[15:0]
  - 3'b101–3'b111: no write and no busy clear, even when wr_enable=1
- A write is effective when wr_enable=1, wr_address≠0 and write_pattern is legal. On the next rising edge the register takes fmt.
- Read port i, in priority order:
  - address 0 → 0
  - an effective write to the same address this cycle → fmt (bypass)
  - otherwise → stored value
- Scoreboard, one busy bit per register:
  - set on an edge when issue_valid=1 and issue_address≠0
  - cleared on an edge by an effective write to that address
  - set and clear to the same register in the same cycle: set wins (a new producer replaces the old one)
- rd_busy[i] = busy[rd_address_i] and not (effective write to rd_address_i this cycle). The bypass covers the write that is completing.
- busy_count is the registered population count of the busy bits. It is updated on the same edge as the bits, so it reflects the post-edge state.

## Timing
- Reads: zero latency; data_out and rd_busy are combinational from addresses, state and the current write inputs.
- Write: stored value visible one cycle later via the array, and in the same cycle via the bypass.
- Scoreboard: issue in cycle N → rd_busy asserted from cycle N+1 until the clearing write's cycle, where it deasserts combinationally.
- Reset (rst_n low, any time, including mid-write or mid-issue):
  - all registers are 0, all busy bits are 0, busy_count = 0 immediately
  - data_out reads 0 and rd_busy = 0, except that bypass of a concurrent effective write is still active combinationally
  - writes and issues are ignored while rst_n is low
- Deassertion: the first capturing edge is the first rising clk edge with rst_n high.
- Simultaneous issue of an already-busy register: the bit stays set, count unchanged.
- Writing a non-busy register: value updates, scoreboard unchanged.

## Test plan
- Reset then read: assert rst_n=0 mid-cycle with busy bits set → every data_out=0, busy_count=0 without a clock edge.
- Width formatting, all with XLEN=32, wr_data=32'h8765_80F0 to x5:
  - BYTE_SIGNED → 32'hFFFF_FFF0
  - BYTE_UNSIGNED → 32'h0000_00F0
  - HALF_SIGNED → 32'hFFFF_80F0
  - WORD → 32'h8765_80F0
  - pattern 3'b111 → x5 unchanged
- Bypass: write 32'hDEAD_BEEF to x7 while port 1 reads x7 → data_out port 1 = 32'hDEAD_BEEF in the same cycle; port 0 reading x0 = 0.
- x0 protection: write 32'hFFFF_FFFF to x0 with issue_valid to x0 → reads 0, busy_count stays 0.
- Scoreboard:
  - issue x3 and x4 → next cycle busy_count=2 and rd_busy set for both
  - write x3 → rd_busy for x3 drops the same cycle, busy_count=1 next cycle
  - issue x4 while writing x4 → x4 remains busy
- Parameter sweep: rerun the above at XLEN=64, NREGS=16, NREAD=3. Sign-extension fills bits [63:8]; all three ports read independently.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with NREAD combinational read ports, one formatted write port,
// same-cycle write-to-read bypass and a per-register busy scoreboard for decode stalls.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   rd_address,
    output logic [NREAD*XLEN-1:0] data_out,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr_enable,
    input  logic [AW-1:0]         wr_address,
    input  logic [XLEN-1:0]       wr_data,
    input  logic [2:0]            write_pattern,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_address,
    output logic [AW:0]           busy_count
);

    localparam logic [2:0] REG_WRITE_WORD          = 3'b000;
    localparam logic [2:0] REG_WRITE_BYTE_UNSIGNED = 3'b001;
    localparam logic [2:0] REG_WRITE_BYTE_SIGNED   = 3'b010;
    localparam logic [2:0] REG_WRITE_HALF_UNSIGNED = 3'b011;
    localparam logic [2:0] REG_WRITE_HALF_SIGNED   = 3'b100;
    localparam int CW = AW + 1;

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [CW-1:0]    count_next;
    logic [XLEN-1:0]  fmt;
    logic             pattern_legal;
    logic             wr_effective;

    always_comb begin
        // NOTE: defaults before the case give every path a value, so no latch is inferred.
        // NOTE: combinational logic uses blocking '='; only clocked state uses '<='.
        fmt           = wr_data;
        pattern_legal = 1'b1;
        case (write_pattern)
            REG_WRITE_WORD:          fmt = wr_data;
            REG_WRITE_BYTE_UNSIGNED: fmt = {{(XLEN-8){1'b0}}, wr_data[7:0]};
            REG_WRITE_BYTE_SIGNED:   fmt = {{(XLEN-8){wr_data[7]}}, wr_data[7:0]};
            REG_WRITE_HALF_UNSIGNED: fmt = {{(XLEN-16){1'b0}}, wr_data[15:0]};
            REG_WRITE_HALF_SIGNED:   fmt = {{(XLEN-16){wr_data[15]}}, wr_data[15:0]};
            default:                 pattern_legal = 1'b0;
        endcase
    end

    assign wr_effective = wr_enable && (wr_address != '0) && pattern_legal;

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [AW-1:0] addr;
        logic          hit;
        assign addr = rd_address[i*AW +: AW];
        assign hit  = wr_effective && (wr_address == addr);
        assign data_out[i*XLEN +: XLEN] = (addr == '0) ? '0 : (hit ? fmt : regs[addr]);
        // The completing write satisfies the dependency, so it masks the busy bit.
        assign rd_busy[i] = busy[addr] && !hit;
    end

    always_comb begin
        busy_next = busy;
        if (wr_effective) busy_next[wr_address] = 1'b0;
        // Applied after the clear: a new producer replaces the one completing now.
        if (issue_valid && (issue_address != '0)) busy_next[issue_address] = 1'b1;
        count_next = '0;
        for (int r = 0; r < NREGS; r++) count_next += CW'(busy_next[r]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset because every register must read 0 straight out of reset.
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else if (wr_effective) begin
            regs[wr_address] <= fmt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two configurations (32x32x2 and 64x16x3) driven in lockstep,
// directed formatting/bypass/scoreboard steps followed by random traffic against an array model.
module tb_regfile_scoreboard;

    localparam int AX = 32, AN = 32, AR = 2, AAW = 5;
    localparam int BX = 64, BN = 16, BR = 3, BAW = 4;
    localparam logic [63:0] WDATA = 64'h0123_4567_8765_80F0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             wr_enable;
    logic [2:0]       write_pattern;
    logic [4:0]       wr_address;
    logic [63:0]      wr_data;
    logic             issue_valid;
    logic [4:0]       issue_address;

    logic [AR*AAW-1:0] a_rd_address;
    logic [AR*AX-1:0]  a_data_out;
    logic [AR-1:0]     a_rd_busy;
    logic [AAW:0]      a_busy_count;
    logic [BR*BAW-1:0] b_rd_address;
    logic [BR*BX-1:0]  b_data_out;
    logic [BR-1:0]     b_rd_busy;
    logic [BAW:0]      b_busy_count;

    regfile_scoreboard #(.XLEN(AX), .NREGS(AN), .NREAD(AR)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .rd_address(a_rd_address), .data_out(a_data_out), .rd_busy(a_rd_busy),
        .wr_enable(wr_enable), .wr_address(wr_address), .wr_data(wr_data[31:0]),
        .write_pattern(write_pattern), .issue_valid(issue_valid),
        .issue_address(issue_address), .busy_count(a_busy_count)
    );

    regfile_scoreboard #(.XLEN(BX), .NREGS(BN), .NREAD(BR)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_address(b_rd_address), .data_out(b_data_out), .rd_busy(b_rd_busy),
        .wr_enable(wr_enable), .wr_address(wr_address[3:0]), .wr_data(wr_data),
        .write_pattern(write_pattern), .issue_valid(issue_valid),
        .issue_address(issue_address[3:0]), .busy_count(b_busy_count)
    );

    logic [63:0] ma [AN];
    logic [63:0] mb [BN];
    bit          ba [AN];
    bit          bb [BN];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [2:0] p);
        return p <= 3'd4;
    endfunction

    // Formatting from the load semantics: take the low byte/half as a number, apply the sign.
    function automatic logic [63:0] fmt_val(input logic [2:0] p, input logic [63:0] d, input int xlen);
        longint v;
        longint b;
        longint h;
        b = longint'(d % 256);
        h = longint'(d % 65536);
        case (p)
            3'd0:    v = longint'(d);
            3'd1:    v = b;
            3'd2:    v = (b >= 128) ? b - 256 : b;
            3'd3:    v = h;
            3'd4:    v = (h >= 32768) ? h - 65536 : h;
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < AN; r++) begin ma[r] = '0; ba[r] = 1'b0; end
        for (int r = 0; r < BN; r++) begin mb[r] = '0; bb[r] = 1'b0; end
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        if (wr_enable && legal(write_pattern) && wr_address != 0) begin
            ma[wr_address] = fmt_val(write_pattern, wr_data, 32);
            ba[wr_address] = 1'b0;
        end
        if (issue_valid && issue_address != 0) ba[issue_address] = 1'b1;
        if (wr_enable && legal(write_pattern) && wr_address[3:0] != 0) begin
            mb[wr_address[3:0]] = fmt_val(write_pattern, wr_data, 64);
            bb[wr_address[3:0]] = 1'b0;
        end
        if (issue_valid && issue_address[3:0] != 0) bb[issue_address[3:0]] = 1'b1;
    endtask

    task automatic check_all(input string tag);
        bit          eff_a, eff_b;
        logic [63:0] f_a, f_b;
        int          ca, cb;
        eff_a = wr_enable && legal(write_pattern) && wr_address != 0;
        eff_b = wr_enable && legal(write_pattern) && wr_address[3:0] != 0;
        f_a   = fmt_val(write_pattern, wr_data, 32);
        f_b   = fmt_val(write_pattern, wr_data, 64);
        for (int i = 0; i < AR; i++) begin
            logic [4:0]  ad;
            logic [63:0] e;
            bit          hit;
            ad  = a_rd_address[i*AAW +: AAW];
            hit = eff_a && (ad == wr_address);
            e   = (ad == 0) ? 64'd0 : (hit ? f_a : ma[ad]);
            check($sformatf("%s a_data%0d", tag, i), 64'(a_data_out[i*AX +: AX]), e);
            check($sformatf("%s a_busy%0d", tag, i), 64'(a_rd_busy[i]), 64'(ba[ad] && !hit));
        end
        for (int i = 0; i < BR; i++) begin
            logic [3:0]  ad;
            logic [63:0] e;
            bit          hit;
            ad  = b_rd_address[i*BAW +: BAW];
            hit = eff_b && (ad == wr_address[3:0]);
            e   = (ad == 0) ? 64'd0 : (hit ? f_b : mb[ad]);
            check($sformatf("%s b_data%0d", tag, i), b_data_out[i*BX +: BX], e);
            check($sformatf("%s b_busy%0d", tag, i), 64'(b_rd_busy[i]), 64'(bb[ad] && !hit));
        end
        ca = 0;
        cb = 0;
        for (int r = 0; r < AN; r++) ca += int'(ba[r]);
        for (int r = 0; r < BN; r++) cb += int'(bb[r]);
        check($sformatf("%s a_count", tag), 64'(a_busy_count), 64'(ca));
        check($sformatf("%s b_count", tag), 64'(b_busy_count), 64'(cb));
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic we, input logic [2:0] pat, input logic [4:0] waddr,
                         input logic [63:0] wdata, input logic iv, input logic [4:0] iaddr);
        wr_enable     = we;
        write_pattern = pat;
        wr_address    = waddr;
        wr_data       = wdata;
        issue_valid   = iv;
        issue_address = iaddr;
    endtask

    logic [2:0]  pats  [5];
    logic [31:0] exp_a [5];
    logic [63:0] exp_b [5];

    initial begin
        pats  = '{3'd2, 3'd1, 3'd4, 3'd0, 3'd7};
        exp_a = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0, 32'h8765_80F0, 32'h8765_80F0};
        exp_b = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_00F0, 64'hFFFF_FFFF_FFFF_80F0,
                  WDATA, WDATA};

        rst_n = 1'b0;
        drive(0, 3'd0, 5'd0, 64'd0, 0, 5'd0);
        a_rd_address = '0;
        b_rd_address = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        cycle("reset_hold");
        rst_n = 1'b1;

        // Width formatting into x5, checked through the bypass and then from storage.
        a_rd_address = {5'd5, 5'd0};
        b_rd_address = {4'd7, 4'd0, 4'd5};
        for (int k = 0; k < 5; k++) begin
            drive(1, pats[k], 5'd5, WDATA, 0, 5'd0);
            #1;
            check($sformatf("fmt%0d a_bypass", k), 64'(a_data_out[63:32]), 64'(exp_a[k]));
            check($sformatf("fmt%0d b_bypass", k), b_data_out[63:0], exp_b[k]);
            cycle("fmt");
            drive(0, 3'd0, 5'd0, 64'd0, 0, 5'd0);
            #1;
            check($sformatf("fmt%0d a_stored", k), 64'(a_data_out[63:32]), 64'(exp_a[k]));
            check($sformatf("fmt%0d b_stored", k), b_data_out[63:0], exp_b[k]);
        end

        // Same-cycle bypass on x7, x0 on the other port.
        a_rd_address = {5'd7, 5'd0};
        b_rd_address = {4'd0, 4'd7, 4'd0};
        drive(1, 3'd0, 5'd7, 64'h0000_0000_DEAD_BEEF, 0, 5'd0);
        #1;
        check("bypass a_p1", 64'(a_data_out[63:32]), 64'hDEAD_BEEF);
        check("bypass a_p0", 64'(a_data_out[31:0]), 64'd0);
        check("bypass b_p1", b_data_out[127:64], 64'hDEAD_BEEF);
        cycle("bypass");

        // x0 is neither written nor marked busy.
        a_rd_address = {5'd0, 5'd0};
        drive(1, 3'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 5'd0);
        #1;
        check("x0 a_p0", 64'(a_data_out[31:0]), 64'd0);
        cycle("x0");
        drive(0, 3'd0, 5'd0, 64'd0, 0, 5'd0);
        #1;
        check("x0 a_count", 64'(a_busy_count), 64'd0);
        check("x0 b_count", 64'(b_busy_count), 64'd0);

        // Scoreboard: issue x3 and x4, retire x3, re-issue x4 while it retires.
        a_rd_address = {5'd4, 5'd3};
        b_rd_address = {4'd3, 4'd4, 4'd3};
        drive(0, 3'd0, 5'd0, 64'd0, 1, 5'd3);
        cycle("issue3");
        drive(0, 3'd0, 5'd0, 64'd0, 1, 5'd4);
        cycle("issue4");
        drive(0, 3'd0, 5'd0, 64'd0, 0, 5'd0);
        #1;
        check("sb a_count2", 64'(a_busy_count), 64'd2);
        check("sb b_count2", 64'(b_busy_count), 64'd2);
        check("sb a_busy34", 64'(a_rd_busy), 64'b11);
        drive(1, 3'd0, 5'd3, 64'h11, 0, 5'd0);
        #1;
        check("sb a_busy_drop3", 64'(a_rd_busy), 64'b10);
        check("sb b_busy_drop3", 64'(b_rd_busy), 64'b010);
        cycle("write3");
        drive(0, 3'd0, 5'd0, 64'd0, 0, 5'd0);
        #1;
        check("sb a_count1", 64'(a_busy_count), 64'd1);
        drive(1, 3'd0, 5'd4, 64'h22, 1, 5'd4);
        cycle("set_wins");
        drive(0, 3'd0, 5'd0, 64'd0, 0, 5'd0);
        #1;
        check("sb a_count_setwins", 64'(a_busy_count), 64'd1);
        check("sb a_busy4_setwins", 64'(a_rd_busy[1]), 64'd1);

        // Asynchronous reset mid-cycle with busy bits set and non-zero registers.
        drive(0, 3'd0, 5'd0, 64'd0, 1, 5'd9);
        cycle("issue9");
        drive(0, 3'd0, 5'd0, 64'd0, 0, 5'd0);
        a_rd_address = {5'd7, 5'd5};
        b_rd_address = {4'd7, 4'd5, 4'd4};
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async a_count", 64'(a_busy_count), 64'd0);
        check("async b_count", 64'(b_busy_count), 64'd0);
        check("async a_data", 64'(a_data_out), 64'd0);
        check("async b_data_p0", b_data_out[63:0], 64'd0);
        check("async b_data_p2", b_data_out[191:128], 64'd0);
        cycle("in_reset");
        cycle("in_reset");
        rst_n = 1'b1;

        // Random traffic with occasional one-cycle resets.
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            if (!rst_n) model_reset();
            wr_enable     = ($urandom_range(0, 3) != 0);
            write_pattern = 3'($urandom_range(0, 7));
            wr_address    = 5'($urandom);
            wr_data       = {$urandom, $urandom};
            issue_valid   = 1'($urandom_range(0, 1));
            issue_address = ($urandom_range(0, 2) == 0) ? wr_address : 5'($urandom);
            a_rd_address  = 10'($urandom);
            b_rd_address  = 12'($urandom);
            if ($urandom_range(0, 2) == 0) a_rd_address[4:0] = wr_address;
            if ($urandom_range(0, 2) == 0) a_rd_address[9:5] = issue_address;
            if ($urandom_range(0, 2) == 0) b_rd_address[7:4] = wr_address[3:0];
            if ($urandom_range(0, 2) == 0) b_rd_address[11:8] = issue_address[3:0];
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
